fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset; bits [1:0] SHALL be treated as zero.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 redirect_i  input  1  branch/jump redirect request, sampled at the clock edge.
REQ-005 redirect_pc_i  input  32  redirect target; bits [1:0] SHALL be ignored and forced to zero.
REQ-006 imem_addr_o  output  32  byte address to instruction memory; SHALL equal the current PC register.
REQ-007 imem_inst_i  input  32  instruction word returned combinationally by instruction memory for imem_addr_o.
REQ-008 out_valid_o  output  1  head entry valid toward decode.
REQ-009 out_ready_i  input  1  decode accepts the head entry.
REQ-010 out_pc_o  output  32  PC of the head entry.
REQ-011 out_inst_o  output  32  instruction of the head entry.

Function
REQ-012 State: PC register pc_q plus a 2-entry FIFO of {pc, inst}; occupancy count 0..2.
REQ-013 pop SHALL be out_valid_o && out_ready_i; out_valid_o SHALL equal (count != 0).
REQ-014 push SHALL be !redirect_i && (count < 2 || pop); on push, {pc_q, imem_inst_i} enters the FIFO tail and pc_q <= pc_q + 4.
REQ-015 pc_q + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no flag and no stall.
REQ-016 Push and pop in the same cycle at count 2 SHALL leave count at 2 with FIFO order preserved; push and pop at count 1 SHALL leave count at 1.
REQ-017 When redirect_i is high, the FIFO SHALL be cleared to count 0, pc_q SHALL be loaded with {redirect_pc_i[31:2], 2'b00}, and there SHALL be no push.
REQ-018 A pop in a redirect cycle SHALL count as a completed transfer; the redirect still clears all entries.
REQ-019 Latency: a redirect at edge N SHALL make the target fetch at cycle N+1, with out_valid_o high and out_pc_o equal to the target from cycle N+2.
REQ-020 While out_valid_o is high and out_ready_i is low, out_pc_o and out_inst_o SHALL hold stable.
REQ-021 When out_valid_o is low, out_pc_o and out_inst_o SHALL be driven to 32'h0.
REQ-022 With out_ready_i held high and no redirect, sustained throughput SHALL be one instruction per cycle.

Reset
REQ-023 When rst_ni is low, the block SHALL asynchronously set pc_q to RESET_PC, count to 0, and FIFO storage to 0, which gives out_valid_o=0, out_pc_o=0, out_inst_o=0 and imem_addr_o=RESET_PC.
REQ-024 Reset asserted mid-operation SHALL discard all buffered entries and any same-cycle redirect.
REQ-025 The first push SHALL occur in the first cycle after rst_ni deasserts, and out_valid_o SHALL rise one cycle later.

Structure
REQ-026 The shared package SHALL hold: XLEN=32, FETCH_DEPTH=2, the default RESET_PC constant, and the typedef fetch_entry_t {pc[31:0], inst[31:0]}.
REQ-027 The FIFO SHALL be a sub-module named fetch_fifo with push/pop/flush, a fetch_entry_t data port, count and async active-low reset; PC logic stays in fetch_stage.

Verification
REQ-028 Scenario: reset release with out_ready_i=1 and imem returning mem[addr>>2] -> out_pc_o = 0x0, 0x4, 0x8 on consecutive cycles, each with the matching instruction.
REQ-029 Scenario: out_ready_i=0 for 5 cycles after reset -> count saturates at 2, pc_q=0x8, head stays pc 0x0; raising out_ready_i then delivers 0x0, 0x4, 0x8 with no gap.
REQ-030 Scenario: redirect_i=1, redirect_pc_i=0x0000_0103 while count=2 and out_ready_i=1 -> next cycle out_valid_o=0, imem_addr_o=0x100; the cycle after, out_pc_o=0x100.
REQ-031 Scenario: redirect to 0xFFFF_FFF8, then run free -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
REQ-032 Scenario: rst_ni pulsed low mid-stream between clock edges with count=2 -> outputs go to zero immediately without a clock edge; after release the fetch restarts at RESET_PC.
REQ-033 The bench SHALL check continuously that no instruction is duplicated or dropped across stalls, using a scoreboard compared against a PC-ordered reference.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
// Shared definitions for the instruction fetch stage: datapath width,
// buffer depth, the default reset PC and the {pc, inst} record that
// travels from fetch toward decode.
package fetch_stage_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_DEPTH = 2;
  localparam int CNT_W       = $clog2(FETCH_DEPTH + 1);

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned, so the two low address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Two-entry in-order buffer of fetched {pc, inst} records.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears count and storage
//   push   - write wdata at the tail
//   pop    - discard the head entry
//   flush  - drop every entry (takes priority over push/pop)
//   wdata  - record to write
//   head   - oldest record (only meaningful while count != 0)
//   count  - occupancy, 0..FETCH_DEPTH
// The caller never pushes into a full buffer unless it pops in the same cycle.
module fetch_fifo
  import fetch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FETCH_DEPTH);

  fetch_entry_t entry0;
  fetch_entry_t entry1;
  logic [CNT_W-1:0] count_q;

  // entry0 is always the head; a pop shifts entry1 forward so that the
  // output never needs a read pointer mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0  <= '0;
      entry1  <= '0;
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == '0) entry0 <= wdata;
          else               entry1 <= wdata;
          count_q <= count_q + 1'b1;
        end
        2'b01: begin
          entry0  <= entry1;
          count_q <= count_q - 1'b1;
        end
        2'b11: begin
          // Simultaneous push and pop keeps occupancy; when full the new
          // record lands behind the one that moves into the head slot.
          if (count_q == FULL) begin
            entry0 <= entry1;
            entry1 <= wdata;
          end else begin
            entry0 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry0;
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction fetch: holds the PC, reads instruction memory combinationally
// and buffers up to two {pc, inst} records toward decode.
// Ports:
//   clk_i         - clock, rising edge
//   rst_ni        - asynchronous active-low reset
//   redirect_i    - branch/jump redirect, flushes the buffer
//   redirect_pc_i - redirect target (low two bits ignored)
//   imem_addr_o   - fetch address, equal to the PC register
//   imem_inst_i   - instruction returned for imem_addr_o in the same cycle
//   out_valid_o   - head record valid
//   out_ready_i   - decode accepts the head record
//   out_pc_o      - head record PC (zero when not valid)
//   out_inst_o    - head record instruction (zero when not valid)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_inst_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [XLEN-1:0] out_inst_o
);

  localparam logic [XLEN-1:0]  START_PC = word_align(RESET_PC);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FETCH_DEPTH);

  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             pop;
  logic             push;
  fetch_entry_t     wdata;
  fetch_entry_t     head;

  assign valid = (count != '0);
  assign pop   = valid && out_ready_i;
  // A pop frees a slot in the same cycle, which is what sustains one
  // instruction per cycle with a full buffer.
  assign push  = !redirect_i && ((count < FULL) || pop);

  assign wdata.pc   = pc_q;
  assign wdata.inst = imem_inst_i;

  // The redirect wins over the sequential increment; the adder wraps
  // naturally at the top of the address space.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= START_PC;
    end else if (redirect_i) begin
      pc_q <= word_align(redirect_pc_i);
    end else if (push) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign imem_addr_o = pc_q;
  assign out_valid_o = valid;
  assign out_pc_o    = valid ? head.pc   : '0;
  assign out_inst_o  = valid ? head.inst : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// Directed bench for fetch_stage: a vector table for steady-state, redirect
// and wrap behaviour, hand-written sequences for stall and async reset, and
// an always-on scoreboard checking accepted records against PC order.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_pc;

  typedef struct {
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs [15];

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_inst_i   (imem_inst_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_pc_o      (out_pc_o),
    .out_inst_o    (out_inst_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory model: a distinct word for every address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  assign imem_inst_i = inst_of(imem_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input logic exp_valid,
                              input logic [31:0] exp_pc, input logic [31:0] exp_addr);
    check({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, exp_valid});
    check({tag, ".addr"},  imem_addr_o, exp_addr);
    check({tag, ".pc"},    out_pc_o,   exp_valid ? exp_pc : 32'h0);
    check({tag, ".inst"},  out_inst_o, exp_valid ? inst_of(exp_pc) : 32'h0);
  endtask

  task automatic apply_stimulus(input logic redirect, input logic [31:0] rpc, input logic ready);
    redirect_i    = redirect;
    redirect_pc_i = rpc;
    out_ready_i   = ready;
  endtask

  // Scoreboard: every accepted record must carry the next PC in program
  // order and its matching instruction; redirects and resets reseed it.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_pc = RST_PC;
    end else begin
      if (out_valid_o && out_ready_i) begin
        check("sb.pc", out_pc_o, sb_pc);
        check("sb.inst", out_inst_o, inst_of(sb_pc));
        sb_pc = sb_pc + 32'd4;
      end
      if (redirect_i) sb_pc = {redirect_pc_i[31:2], 2'b00};
    end
  end

  initial begin
    //           redir  target         rdy   valid  pc             addr
    vecs[0]  = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          32'h0};
    vecs[1]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0,          32'h4};
    vecs[2]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h4,          32'h8};
    vecs[3]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h8,          32'hC};
    vecs[4]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h8,          32'h10};
    vecs[5]  = '{1'b0, 32'h0,          1'b0, 1'b1, 32'h8,          32'h10};
    vecs[6]  = '{1'b1, 32'h0000_0103,  1'b1, 1'b1, 32'h8,          32'h10};
    vecs[7]  = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          32'h100};
    vecs[8]  = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h100,        32'h104};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFB,  1'b1, 1'b1, 32'h104,        32'h108};
    vecs[10] = '{1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          32'hFFFF_FFF8};
    vecs[11] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFC};
    vecs[12] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'hFFFF_FFFC,  32'h0};
    vecs[13] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h0,          32'h4};
    vecs[14] = '{1'b0, 32'h0,          1'b1, 1'b1, 32'h4,          32'h8};

    rst_ni = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1 check_output("reset", 1'b0, 32'h0, RST_PC);
    rst_ni = 1'b1;
    @(negedge clk_i);
    // The clock edge after release already fetched, so rewind by asserting
    // reset again and releasing it exactly at the negedge used by the table.
    rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
    #0;

    // Table: run, stall to full, redirect at full, redirect with wrap.
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i].redirect, vecs[i].redirect_pc, vecs[i].ready);
      #1 check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_addr);
      @(posedge clk_i);
      @(negedge clk_i);
    end

    // Stall right after reset: buffer fills to two, head holds pc 0.
    apply_stimulus(1'b0, 32'h0, 1'b0);
    rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check_output($sformatf("stall%0d", i), (i != 0), 32'h0,
                      (i == 0) ? 32'h0 : ((i == 1) ? 32'h4 : 32'h8));
      @(posedge clk_i);
      @(negedge clk_i);
    end
    #1 check_output("stall_end", 1'b1, 32'h0, 32'h8);
    out_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 check_output($sformatf("drain%0d", k), 1'b1, 32'(k * 4), 32'(8 + k * 4));
      @(posedge clk_i);
      @(negedge clk_i);
    end

    // Async reset mid-cycle with a full buffer and a pending redirect.
    out_ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    #1 check_output("async_rst", 1'b0, 32'h0, RST_PC);
    @(posedge clk_i);
    #1 check_output("rst_held", 1'b0, 32'h0, RST_PC);
    @(negedge clk_i);
    #2 apply_stimulus(1'b0, 32'h0, 1'b1);
    rst_ni = 1'b1;
    #1 check_output("restart0", 1'b0, 32'h0, RST_PC);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      #1 check_output($sformatf("restart%0d", k + 1), 1'b1, RST_PC + 32'(k * 4), RST_PC + 32'(k * 4 + 4));
    end
    @(posedge clk_i);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
